// File: rtl/vrom_arbiter_if.sv
// rtl/vrom_arbiter_if.sv - request/grant/return bundle shared by both requesters, the arbiter and the video ROM
// master: requesters plus ROM data return; slave: the arbiter.
interface vrom_arbiter_if #(
  parameter int ROM_WIDTH     = 12,
  parameter int ROM_ADDR_BITS = 20
);
  logic                     Req0;
  logic [ROM_ADDR_BITS-1:0] Addr0;
  logic                     Gnt0;
  logic                     Valid0;
  logic [ROM_WIDTH-1:0]     Data0;
  logic                     Req1;
  logic [ROM_ADDR_BITS-1:0] Addr1;
  logic                     Gnt1;
  logic                     Valid1;
  logic [ROM_WIDTH-1:0]     Data1;
  logic [ROM_ADDR_BITS-1:0] RomAddr;
  logic [ROM_WIDTH-1:0]     RomData;

  modport master (
    output Req0, Addr0, Req1, Addr1, RomData,
    input  Gnt0, Valid0, Data0, Gnt1, Valid1, Data1, RomAddr
  );

  modport slave (
    input  Req0, Addr0, Req1, Addr1, RomData,
    output Gnt0, Valid0, Data0, Gnt1, Valid1, Data1, RomAddr
  );
endinterface

// File: rtl/vrom_arbiter.sv
// rtl/vrom_arbiter.sv - fixed-priority two-port arbiter for the synchronous video ROM
// Define VROM_ARB_STARVE_EN to build the port 1 anti-starvation counter.
module vrom_arbiter #(
  parameter int ROM_WIDTH     = 12,
  parameter int ROM_ADDR_BITS = 20,
  parameter int STARVE_LIMIT  = 15,
  parameter int CNT_BITS      = 4
) (
  input  logic             CLK,
  input  logic             RST,
  vrom_arbiter_if.slave    bus
);

  logic                 force1;
  logic                 gnt0;
  logic                 gnt1;
  logic                 tag_vld;
  logic                 tag_port;
  logic                 valid0_q;
  logic                 valid1_q;
  logic [ROM_WIDTH-1:0] data0_q;
  logic [ROM_WIDTH-1:0] data1_q;

  // Grants are gated by RST so nothing reaches the ROM while in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!RST) begin
      if (force1)
        gnt1 = 1'b1;
      else if (bus.Req0)
        gnt0 = 1'b1;
      else if (bus.Req1)
        gnt1 = 1'b1;
    end
  end

  assign bus.Gnt0    = gnt0;
  assign bus.Gnt1    = gnt1;
  assign bus.RomAddr = gnt0 ? bus.Addr0 : (gnt1 ? bus.Addr1 : '0);

  // The tag follows the ROM's one-cycle latency so each return lands on its issuer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tag_vld  <= 1'b0;
      tag_port <= 1'b0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      data0_q  <= '0;
      data1_q  <= '0;
    end else begin
      tag_vld  <= gnt0 | gnt1;
      tag_port <= gnt1;
      valid0_q <= tag_vld & ~tag_port;
      valid1_q <= tag_vld & tag_port;
      if (tag_vld && !tag_port)
        data0_q <= bus.RomData;
      if (tag_vld && tag_port)
        data1_q <= bus.RomData;
    end
  end

  assign bus.Valid0 = valid0_q;
  assign bus.Valid1 = valid1_q;
  assign bus.Data0  = data0_q;
  assign bus.Data1  = data1_q;

`ifdef VROM_ARB_STARVE_EN
  localparam logic [CNT_BITS-1:0] LIMIT = CNT_BITS'(STARVE_LIMIT);

  logic [CNT_BITS-1:0] starve_cnt;

  assign force1 = bus.Req1 && (starve_cnt == LIMIT);

  // A dropped port 1 request clears the count, so a later request never inherits a force.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      starve_cnt <= '0;
    else if (!bus.Req1 || gnt1)
      starve_cnt <= '0;
    else if (starve_cnt != LIMIT)
      starve_cnt <= starve_cnt + 1'b1;
  end
`else
  logic unused_cfg;

  assign force1     = 1'b0;
  assign unused_cfg = (STARVE_LIMIT == CNT_BITS);
`endif

endmodule

// File: tb/tb_vrom_arbiter.sv
// tb/tb_vrom_arbiter.sv - randomized and directed bench for vrom_arbiter against a behavioural model
// Starvation expectations follow VROM_ARB_STARVE_EN as compiled.
module tb_vrom_arbiter;

`ifdef VROM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif
  localparam int LIMIT = 15;

  logic CLK;
  logic RST;
  int   total;
  int   bad;

  vrom_arbiter_if #(.ROM_WIDTH(12), .ROM_ADDR_BITS(20)) bus ();

  vrom_arbiter #(
    .ROM_WIDTH(12), .ROM_ADDR_BITS(20), .STARVE_LIMIT(LIMIT), .CNT_BITS(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [11:0] rom_fn(input logic [19:0] a);
    if (a == 20'h00010)
      return 12'hABC;
    return (a[11:0] * 12'd3 + 12'h100) ^ {4'h0, a[19:12]};
  endfunction

  always @(posedge CLK) bus.RomData <= rom_fn(bus.RomAddr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: grant by priority rules, returns two cycles after a grant.
  int          cnt_m;
  int          hg1, hg2;
  logic [19:0] ha1, ha2;
  logic [11:0] ed0, ed1;

  always @(negedge CLK) begin
    int          g;
    logic [19:0] ea;
    bit          frc;
    if (RST) begin
      chk("rst_gnt0", bus.Gnt0, 0);
      chk("rst_gnt1", bus.Gnt1, 0);
      chk("rst_valid0", bus.Valid0, 0);
      chk("rst_valid1", bus.Valid1, 0);
      chk("rst_data0", bus.Data0, 0);
      chk("rst_data1", bus.Data1, 0);
      chk("rst_romaddr", bus.RomAddr, 0);
      cnt_m = 0; hg1 = 0; hg2 = 0; ha1 = '0; ha2 = '0; ed0 = '0; ed1 = '0;
    end else begin
      frc = STARVE_ON && (cnt_m == LIMIT) && bus.Req1;
      g   = frc ? 2 : (bus.Req0 ? 1 : (bus.Req1 ? 2 : 0));
      ea  = (g == 1) ? bus.Addr0 : ((g == 2) ? bus.Addr1 : 20'h0);
      if (hg2 == 1) ed0 = rom_fn(ha2);
      if (hg2 == 2) ed1 = rom_fn(ha2);
      chk("gnt0", bus.Gnt0, (g == 1) ? 1 : 0);
      chk("gnt1", bus.Gnt1, (g == 2) ? 1 : 0);
      chk("romaddr", bus.RomAddr, ea);
      chk("valid0", bus.Valid0, (hg2 == 1) ? 1 : 0);
      chk("valid1", bus.Valid1, (hg2 == 2) ? 1 : 0);
      chk("data0", bus.Data0, ed0);
      chk("data1", bus.Data1, ed1);
      if (bus.Req1 && g != 2)
        cnt_m = (cnt_m < LIMIT) ? cnt_m + 1 : LIMIT;
      else
        cnt_m = 0;
      hg2 = hg1; ha2 = ha1; hg1 = g; ha1 = ea;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic r0, input logic [19:0] a0, input logic r1, input logic [19:0] a1);
    bus.Req0 = r0; bus.Addr0 = a0; bus.Req1 = r1; bus.Addr1 = a1;
  endtask

  task automatic single_read();
    drive(1'b1, 20'h00010, 1'b0, 20'h0);
    @(negedge CLK);
    chk("sr_gnt0", bus.Gnt0, 1);
    chk("sr_romaddr", bus.RomAddr, 20'h00010);
    step();
    drive(1'b0, 20'h0, 1'b0, 20'h0);
    @(negedge CLK);
    chk("sr_early_valid0", bus.Valid0, 0);
    step();
    @(negedge CLK);
    chk("sr_valid0", bus.Valid0, 1);
    chk("sr_data0", bus.Data0, 12'hABC);
    chk("sr_valid1", bus.Valid1, 0);
    step();
  endtask

  initial begin
    int          first1;
    int          g0_cnt;
    logic        g0_first;
    logic        g0_17;
    logic        v0[6], v1[6];
    logic [11:0] d0[6], d1[6];
    logic [11:0] keep0, keep1;
    logic        lg0, lg1;
    total = 0;
    bad   = 0;
    RST   = 1'b1;
    drive(1'b0, 20'h0, 1'b0, 20'h0);
    repeat (3) step();
    RST = 1'b0;
    step();

    single_read();

    // Contention: port 0 wins three times, then port 1 is served.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 20'h00100 + 20'(i), 1'b1, 20'h00200);
      @(negedge CLK);
      chk("cont_gnt0", bus.Gnt0, 1);
      chk("cont_gnt1", bus.Gnt1, 0);
      step();
    end
    drive(1'b0, 20'h0, 1'b1, 20'h00200);
    @(negedge CLK);
    chk("cont_late_gnt1", bus.Gnt1, 1);
    step();
    drive(1'b0, 20'h0, 1'b0, 20'h0);
    step();

    // Starvation: both ports held for 20 cycles.
    first1 = 0; g0_cnt = 0; g0_first = 1'b1; g0_17 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 20'h00300 + 20'(i), 1'b1, 20'h00400);
      @(negedge CLK);
      if (bus.Gnt1 && first1 == 0) begin
        first1   = i;
        g0_first = bus.Gnt0;
      end
      if (bus.Gnt0) g0_cnt++;
      if (i == 17) g0_17 = bus.Gnt0;
      step();
    end
    chk("starve_first_gnt1", first1, STARVE_ON ? 16 : 0);
    chk("starve_gnt0_count", g0_cnt, STARVE_ON ? 19 : 20);
    chk("starve_gnt0_resume", g0_17, 1);
    chk("starve_gnt0_at_force", g0_first, STARVE_ON ? 0 : 1);
    drive(1'b0, 20'h0, 1'b0, 20'h0);
    repeat (3) step();

    // Interleaved streaming on addresses 0..3.
    for (int i = 0; i < 6; i++) begin
      if (i < 4)
        drive(i % 2 == 0, 20'(i), i % 2 == 1, 20'(i));
      else
        drive(1'b0, 20'h0, 1'b0, 20'h0);
      @(negedge CLK);
      v0[i] = bus.Valid0; d0[i] = bus.Data0;
      v1[i] = bus.Valid1; d1[i] = bus.Data1;
      step();
    end
    chk("il_v0_2", v0[2], 1); chk("il_d0_2", d0[2], 12'h100);
    chk("il_v1_2", v1[2], 0);
    chk("il_v1_3", v1[3], 1); chk("il_d1_3", d1[3], 12'h103);
    chk("il_v0_3", v0[3], 0); chk("il_d0_3", d0[3], 12'h100);
    chk("il_v0_4", v0[4], 1); chk("il_d0_4", d0[4], 12'h106);
    chk("il_v1_5", v1[5], 1); chk("il_d1_5", d1[5], 12'h109);

    // Reset between the grant edge and the return edge.
    drive(1'b1, 20'h00005, 1'b0, 20'h0);
    step();
    drive(1'b0, 20'h0, 1'b0, 20'h0);
    RST = 1'b1;
    @(negedge CLK);
    chk("mr_valid0", bus.Valid0, 0);
    chk("mr_data0", bus.Data0, 0);
    step();
    @(negedge CLK);
    chk("mr_valid0_late", bus.Valid0, 0);
    step();
    RST = 1'b0;
    single_read();

    // Idle: nothing granted, data held.
    repeat (2) step();
    keep0 = bus.Data0;
    keep1 = bus.Data1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("idle_gnt", {bus.Gnt0, bus.Gnt1}, 0);
      chk("idle_romaddr", bus.RomAddr, 0);
      chk("idle_data", {bus.Data0, bus.Data1}, {keep0, keep1});
      step();
    end

    // Randomized traffic obeying the hold-until-granted handshake.
    lg0 = 1'b0; lg1 = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!bus.Req0 || lg0) begin
        bus.Req0  = ($urandom_range(0, 3) != 0);
        bus.Addr0 = 20'($urandom);
      end
      if (!bus.Req1 || lg1) begin
        bus.Req1  = ($urandom_range(0, 1) != 0);
        bus.Addr1 = 20'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        bus.Req1 = 1'b0;
      end
      RST = ($urandom_range(0, 99) == 0);
      @(negedge CLK);
      lg0 = bus.Gnt0;
      lg1 = bus.Gnt1;
      step();
    end
    RST = 1'b0;
    drive(1'b0, 20'h0, 1'b0, 20'h0);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vrom_arbiter.md
# vrom_arbiter

Two-port arbiter that shares the single synchronous video ROM (12-bit data, 20-bit address, one-cycle read latency) between the VGA pixel fetcher (port 0, high priority) and an auxiliary reader (port 1, e.g. a sprite or debug path). It sits between both requesters and the ROM: it drives the ROM address, tags each read, and returns the data with a valid strobe to the port that issued it. It also has an optional anti-starvation guard so port 1 is eventually served while port 0 saturates.

## Interface
- ROM_WIDTH, 12, ROM data width.
- ROM_ADDR_BITS, 20, ROM address width.
- STARVE_LIMIT, 15, consecutive denied cycles before port 1 is forced; must satisfy 1 ≤ STARVE_LIMIT ≤ 2^CNT_BITS−1.
- CNT_BITS, 4, starvation counter width.

Ports:
- CLK  in  1  system clock, all state on posedge.
- RST  in  1  asynchronous, active-high reset.
- Req0  in  1  port 0 request.
- Addr0  in  ROM_ADDR_BITS  port 0 address.
- Gnt0  out  1  port 0 grant, combinational.
- Valid0  out  1  port 0 read data valid, registered.
- Data0  out  ROM_WIDTH  port 0 read data, registered.
- Req1, Addr1, Gnt1, Valid1, Data1: same as port 0, for port 1.
- RomAddr  out  ROM_ADDR_BITS  to ROM Address, combinational.
- RomData  in  ROM_WIDTH  from ROM DataOut.

## Operation
- Handshake: the requester holds ReqX and AddrX stable until GntX is high. The transfer happens at the rising edge where ReqX & GntX. The requester may change AddrX or drop ReqX in the cycle after the grant. Back-to-back grants to either port are allowed every cycle.
- Arbitration, evaluated combinationally each cycle:
  - if Force1 then grant port 1;
  - else if Req0 then grant port 0;
  - else if Req1 then grant port 1;
  - else no grant.
- At most one grant per cycle.
- RomAddr equals the granted port's address. With no grant it is all zeros.
- Tag pipeline: at a grant edge, register {issue, port}. At the next edge, capture RomData into DataX of the tagged port and set ValidX for one cycle.
- DataX holds its last value when ValidX is low. The other port's Data is untouched.
- Starvation counter (StarveCnt):
  - increments at each edge where Req1 & !Gnt1;
  - saturates at STARVE_LIMIT;
  - clears to 0 at any edge where Gnt1 is high or Req1 is low.
- Force1 is high when StarveCnt == STARVE_LIMIT and Req1 is high. That cycle, Gnt0 is low even if Req0 is high.
- Reset (any time, including mid-read):
  - Gnt0, Gnt1, Valid0, Valid1 = 0; Data0, Data1 = 0; RomAddr = 0;
  - StarveCnt = 0; tag pipeline cleared.
  - In-flight reads are discarded with no Valid produced. Grants are suppressed while RST is high.

## Timing
- Grant: same cycle as the request, with zero wait when uncontested.
- Read latency: the grant edge is edge N. The ROM registers the address at N. The arbiter captures data at N+1. ValidX and DataX are high/valid in the cycle after N+1 (2 edges after the grant).
- Throughput: one read per cycle in aggregate. Returns come back in issue order.
- Port 1 worst-case wait with port 0 saturated: STARVE_LIMIT+1 cycles with the guard compiled in. Unbounded without it.
- Simultaneous Req0 and Req1 with the counter below the limit: port 0 wins and StarveCnt increments.
- A port 1 request that is dropped before being granted clears StarveCnt. There is no stale force.

## Configuration
- VROM_ARB_STARVE_EN:
  - Defined: the starvation counter and Force1 are implemented as described.
  - Undefined: strict fixed priority, Force1 tied to 0, and no counter logic. STARVE_LIMIT and CNT_BITS are ignored.

## Test plan
- Single read: Req0=1 with Addr0=20'h00010 for one cycle (ROM[0x10]=12'hABC) → Gnt0=1 that cycle; RomAddr=20'h00010; Valid0=1 and Data0=12'hABC two edges later; Valid1 stays 0.
- Contention: Req0 and Req1 held together for 3 cycles → Gnt0=1 and Gnt1=0 each cycle; StarveCnt reaches 3; after Req0 drops, Gnt1=1 and the counter clears.
- Starvation (macro defined, STARVE_LIMIT=15): Req0 and Req1 held for 20 cycles → Gnt1=1 exactly at cycle 16 with Gnt0=0 that cycle, then Gnt0 resumes. Same run with the macro undefined → Gnt1 is never asserted.
- Interleaved streaming: alternate grants 0,1,0,1 on addresses 0..3 → Valid0/Valid1 alternate two edges after each grant, each port receiving only its own data (ROM[0], ROM[2] on port 0; ROM[1], ROM[3] on port 1).
- Reset mid-read: assert RST between a grant edge and its return edge → no Valid pulse appears; all outputs are 0 during reset; first grant after reset release behaves as in the single-read scenario.
- Idle: no requests for 10 cycles → RomAddr=0, both grants 0, Data0/Data1 unchanged.
